// File: rtl/fork_branch_buffer.sv
// Two-entry FIFO holding one half of the forked word for one consumer.
// up_rdy comes straight from the count register, so it does not depend
// combinationally on down_rdy.
module fork_branch_buffer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [width-1:0] up_data,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [width-1:0] down_data
);

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [width-1:0] mem [2];
  logic             push;
  logic             pop;

  assign up_rdy    = (count != 2'd2);
  assign down_vld  = (count != 2'd0);
  assign down_data = mem[rd_ptr];
  assign push      = up_vld & up_rdy;
  assign pop       = down_vld & down_rdy;

  // Occupancy and pointer bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Storage is not reset; its content is only observed while down_vld is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up_data;
  end

endmodule

// File: rtl/splitter_with_flow_control.sv
// Forks one stream of packed {a, b} words into two independent streams.
// Each half is written into its branch buffer exactly once; done flags
// remember which halves of the current word are already stored, so a
// stalled consumer on one side only blocks the word, never duplicates it.
module splitter_with_flow_control #(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_vld,
  output logic               up_rdy,
  input  logic [2*width-1:0] up_data,
  output logic               a_vld,
  input  logic               a_rdy,
  output logic [width-1:0]   a_data,
  output logic               b_vld,
  input  logic               b_rdy,
  output logic [width-1:0]   b_data
);

  logic done_a;
  logic done_b;
  logic bufa_up_rdy;
  logic bufb_up_rdy;
  logic fire_a;
  logic fire_b;
  logic take;

  assign fire_a = up_vld & ~done_a & bufa_up_rdy;
  assign fire_b = up_vld & ~done_b & bufb_up_rdy;
  assign up_rdy = (done_a | bufa_up_rdy) & (done_b | bufb_up_rdy);
  assign take   = up_vld & up_rdy;

  // Track which halves of the word on up_data have been stored; clear when the word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else if (take) begin
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      done_a <= done_a | fire_a;
      done_b <= done_b | fire_b;
    end
  end

  fork_branch_buffer #(.width(width)) u_buf_a (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (up_vld & ~done_a),
    .up_rdy    (bufa_up_rdy),
    .up_data   (up_data[2*width-1:width]),
    .down_vld  (a_vld),
    .down_rdy  (a_rdy),
    .down_data (a_data)
  );

  fork_branch_buffer #(.width(width)) u_buf_b (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (up_vld & ~done_b),
    .up_rdy    (bufb_up_rdy),
    .up_data   (up_data[width-1:0]),
    .down_vld  (b_vld),
    .down_rdy  (b_rdy),
    .down_data (b_data)
  );

endmodule

// File: tb/tb_splitter_with_flow_control.sv
// Bench for splitter_with_flow_control: a queue-based model of the two
// branches checked every cycle, plus directed literal expectations.
module tb_splitter_with_flow_control;

  localparam int W = 8;
  localparam int BUDGET = 1000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           up_vld = 1'b0;
  logic           up_rdy;
  logic [2*W-1:0] up_data = '0;
  logic           a_vld;
  logic           a_rdy = 1'b0;
  logic [W-1:0]   a_data;
  logic           b_vld;
  logic           b_rdy = 1'b0;
  logic [W-1:0]   b_data;

  int tests = 0;
  int fails = 0;

  splitter_with_flow_control #(.width(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_vld  (up_vld),
    .up_rdy  (up_rdy),
    .up_data (up_data),
    .a_vld   (a_vld),
    .a_rdy   (a_rdy),
    .a_data  (a_data),
    .b_vld   (b_vld),
    .b_rdy   (b_rdy),
    .b_data  (b_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: each branch is a queue of halves stored but not yet consumed.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] a_log[$];
  logic [W-1:0] b_log[$];
  bit           taken_a = 0;
  bit           taken_b = 0;
  bit           armed = 0;
  bit           hold_a = 0;
  bit           hold_b = 0;
  logic [W-1:0] held_a;
  logic [W-1:0] held_b;

  always @(negedge clk) begin
    int  na;
    int  nb;
    bit  exp_rdy;
    na = qa.size();
    nb = qb.size();
    exp_rdy = (taken_a || na < 2) && (taken_b || nb < 2);
    if (armed) begin
      check("up_rdy", 32'(up_rdy), 32'(exp_rdy));
      check("a_vld", 32'(a_vld), 32'(na != 0));
      check("b_vld", 32'(b_vld), 32'(nb != 0));
      if (na != 0) check("a_data", 32'(a_data), 32'(qa[0]));
      if (nb != 0) check("b_data", 32'(b_data), 32'(qb[0]));
      if (hold_a) check("a_hold", 32'({a_vld, a_data}), 32'({1'b1, held_a}));
      if (hold_b) check("b_hold", 32'({b_vld, b_data}), 32'({1'b1, held_b}));
    end
    if (rst) begin
      qa.delete();
      qb.delete();
      taken_a = 0;
      taken_b = 0;
      hold_a  = 0;
      hold_b  = 0;
      armed   = 1;
    end else if (armed) begin
      hold_a = a_vld && !a_rdy;
      hold_b = b_vld && !b_rdy;
      held_a = a_data;
      held_b = b_data;
      if (a_vld && a_rdy && na > 0) a_log.push_back(qa.pop_front());
      if (b_vld && b_rdy && nb > 0) b_log.push_back(qb.pop_front());
      if (up_vld && !taken_a && na < 2) begin
        qa.push_back(up_data[2*W-1:W]);
        taken_a = 1;
      end
      if (up_vld && !taken_b && nb < 2) begin
        qb.push_back(up_data[W-1:0]);
        taken_b = 1;
      end
      if (up_vld && exp_rdy) begin
        taken_a = 0;
        taken_b = 0;
      end
    end
  end

  function automatic logic [W-1:0] alog_at(input int i);
    if (i < a_log.size()) return a_log[i];
    return 'x;
  endfunction

  function automatic logic [W-1:0] blog_at(input int i);
    if (i < b_log.size()) return b_log[i];
    return 'x;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a word and hold it until the handshake completes.
  task automatic send_word(input logic [2*W-1:0] w, input bit rand_rdy);
    bit hs;
    int n;
    up_vld  = 1'b1;
    up_data = w;
    hs = 0;
    n  = 0;
    while (!hs) begin
      @(negedge clk);
      hs = up_rdy;
      step();
      if (rand_rdy) begin
        a_rdy = ($urandom_range(0, 3) != 0);
        b_rdy = ($urandom_range(0, 3) != 0);
      end
      n++;
      if (n > BUDGET) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout: word %h not accepted within %0d cycles", w, BUDGET);
        break;
      end
    end
    up_vld = 1'b0;
  endtask

  task automatic do_reset();
    up_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int a0;
    int b0;
    logic [2*W-1:0] sent[$];
    logic [2*W-1:0] w;

    step();
    do_reset();
    check("reset_a_vld", 32'(a_vld), 32'(0));
    check("reset_b_vld", 32'(b_vld), 32'(0));
    check("reset_up_rdy", 32'(up_rdy), 32'(1));

    // Test 5: idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_vlds", 32'({a_vld, b_vld}), 32'(0));
      check("idle_up_rdy", 32'(up_rdy), 32'(1));
    end

    // Test 1: both consumers ready, back-to-back words
    a_rdy = 1'b1;
    b_rdy = 1'b1;
    a0 = a_log.size();
    b0 = b_log.size();
    send_word(16'h1234, 0);
    check("t1_lat_a", 32'({a_vld, a_data}), 32'({1'b1, 8'h12}));
    check("t1_lat_b", 32'({b_vld, b_data}), 32'({1'b1, 8'h34}));
    check("t1_up_rdy", 32'(up_rdy), 32'(1));
    send_word(16'h5678, 0);
    check("t1_lat_a2", 32'({a_vld, a_data}), 32'({1'b1, 8'h56}));
    check("t1_up_rdy2", 32'(up_rdy), 32'(1));
    repeat (3) step();
    check("t1_a0", 32'(alog_at(a0)), 32'(8'h12));
    check("t1_a1", 32'(alog_at(a0 + 1)), 32'(8'h56));
    check("t1_b0", 32'(blog_at(b0)), 32'(8'h34));
    check("t1_b1", 32'(blog_at(b0 + 1)), 32'(8'h78));
    check("t1_a_count", 32'(a_log.size() - a0), 32'(2));

    // Test 2: b stalled
    a_rdy = 1'b1;
    b_rdy = 1'b0;
    a0 = a_log.size();
    b0 = b_log.size();
    send_word(16'hA1B2, 0);
    send_word(16'hC3D4, 0);
    up_vld  = 1'b1;
    up_data = 16'hE5F6;
    repeat (4) step();
    check("t2_up_rdy_stall", 32'(up_rdy), 32'(0));
    check("t2_a0", 32'(alog_at(a0)), 32'(8'hA1));
    check("t2_a1", 32'(alog_at(a0 + 1)), 32'(8'hC3));
    check("t2_a2", 32'(alog_at(a0 + 2)), 32'(8'hE5));
    check("t2_b_none", 32'(b_log.size() - b0), 32'(0));
    b_rdy = 1'b1;
    send_word(16'hE5F6, 0);
    repeat (4) step();
    check("t2_b0", 32'(blog_at(b0)), 32'(8'hB2));
    check("t2_b1", 32'(blog_at(b0 + 1)), 32'(8'hD4));
    check("t2_b2", 32'(blog_at(b0 + 2)), 32'(8'hF6));
    check("t2_a_count", 32'(a_log.size() - a0), 32'(3));
    check("t2_b_count", 32'(b_log.size() - b0), 32'(3));
    check("t2_up_rdy_back", 32'(up_rdy), 32'(1));

    // Test 3: a stalled
    a_rdy = 1'b0;
    b_rdy = 1'b1;
    a0 = a_log.size();
    b0 = b_log.size();
    send_word(16'hA1B2, 0);
    send_word(16'hC3D4, 0);
    up_vld  = 1'b1;
    up_data = 16'hE5F6;
    repeat (4) step();
    check("t3_up_rdy_stall", 32'(up_rdy), 32'(0));
    check("t3_b0", 32'(blog_at(b0)), 32'(8'hB2));
    check("t3_b1", 32'(blog_at(b0 + 1)), 32'(8'hD4));
    check("t3_b2", 32'(blog_at(b0 + 2)), 32'(8'hF6));
    check("t3_a_none", 32'(a_log.size() - a0), 32'(0));
    a_rdy = 1'b1;
    send_word(16'hE5F6, 0);
    repeat (4) step();
    check("t3_a0", 32'(alog_at(a0)), 32'(8'hA1));
    check("t3_a1", 32'(alog_at(a0 + 1)), 32'(8'hC3));
    check("t3_a2", 32'(alog_at(a0 + 2)), 32'(8'hE5));
    check("t3_a_count", 32'(a_log.size() - a0), 32'(3));
    check("t3_b_count", 32'(b_log.size() - b0), 32'(3));

    // Test 4: reset with done_a set and both buffers holding data
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    a_rdy = 1'b1;
    step();
    a_rdy = 1'b0;
    up_vld  = 1'b1;
    up_data = 16'h3333;
    repeat (2) step();
    check("t4_pre_up_rdy", 32'(up_rdy), 32'(0));
    check("t4_pre_vlds", 32'({a_vld, b_vld}), 32'(2'b11));
    do_reset();
    check("t4_post_vlds", 32'({a_vld, b_vld}), 32'(0));
    check("t4_post_up_rdy", 32'(up_rdy), 32'(1));
    a_rdy = 1'b1;
    b_rdy = 1'b1;
    a0 = a_log.size();
    b0 = b_log.size();
    send_word(16'h0F0F, 0);
    repeat (3) step();
    check("t4_a", 32'(alog_at(a0)), 32'(8'h0F));
    check("t4_b", 32'(blog_at(b0)), 32'(8'h0F));
    check("t4_a_count", 32'(a_log.size() - a0), 32'(1));
    check("t4_b_count", 32'(b_log.size() - b0), 32'(1));

    // Test 6: random traffic
    a0 = a_log.size();
    b0 = b_log.size();
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        a_rdy = ($urandom_range(0, 3) != 0);
        b_rdy = ($urandom_range(0, 3) != 0);
      end
      w = 16'($urandom);
      sent.push_back(w);
      send_word(w, 1);
    end
    a_rdy = 1'b1;
    b_rdy = 1'b1;
    repeat (6) step();
    check("t6_a_count", 32'(a_log.size() - a0), 32'(2000));
    check("t6_b_count", 32'(b_log.size() - b0), 32'(2000));
    check("t6_drained", 32'({a_vld, b_vld}), 32'(0));
    for (int i = 0; i < 2000; i++) begin
      check("t6_a_order", 32'(alog_at(a0 + i)), 32'(sent[i][15:8]));
      check("t6_b_order", 32'(blog_at(b0 + i)), 32'(sent[i][7:0]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
